// File: rtl/rr_arbiter8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter8_pkg
// Description : Shared definitions for the 8-way round-robin arbiter:
//               requester count, FSM state encoding and the rotating
//               priority pick helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arbiter8_pkg;

    localparam int ARB_N = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Rotating priority search: starts one above ptr, ascending, wrapping.
    // The final candidate is ptr itself, so a sole requester sitting at the
    // pointer position is still found.
    function automatic pick_t rr_pick(input logic [ARB_N-1:0] req,
                                      input logic [2:0]       ptr);
        pick_t      res;
        logic [2:0] cand;
        res = '0;
        for (int i = 1; i <= ARB_N; i++) begin
            cand = ptr + 3'(i);
            if (!res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter8_enc.sv
`default_nettype none
// ============================================================================
// Module      : bin_encoder8to3
// Description : One-hot (or zero) to 3-bit binary encoder. An all-zero
//               input encodes to 3'b000.
// Ports       : onehot [7:0] in  - one-hot vector
//               idx    [2:0] out - binary index of the set bit
// Revision    : 1.0 - initial release
// ============================================================================
module bin_encoder8to3 (
    input  logic [7:0] onehot,
    output logic [2:0] idx
);

    // OR-reduction form: valid for one-hot input, yields 0 for zero input.
    assign idx[0] = onehot[1] | onehot[3] | onehot[5] | onehot[7];
    assign idx[1] = onehot[2] | onehot[3] | onehot[6] | onehot[7];
    assign idx[2] = onehot[4] | onehot[5] | onehot[6] | onehot[7];

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter8
// Description : Round-robin arbiter for 8 requesters with registered one-hot
//               grant, maximum hold time and optional idle gap between owners.
// Ports       : clk       in       - clock, rising edge
//               rst_n     in       - asynchronous active-low reset
//               req       in  [7:0]- request vector
//               gnt       out [7:0]- registered one-hot grant (0 = no owner)
//               gnt_idx   out [2:0]- binary index of gnt (0 when gnt = 0)
//               gnt_valid out      - registered, high when gnt != 0
//               timeout   out      - one-cycle pulse when gnt clears on
//                                    hold-time expiry
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD   = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int c_hold_w = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last =
        c_hold_w'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [c_hold_w-1:0] c_hold_max = '1;
    localparam logic [3:0] c_gap_last =
        4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    arb_state_t          r_state,    w_state_nxt;
    logic [7:0]          r_gnt,      w_gnt_nxt;
    logic [2:0]          r_ptr,      w_ptr_nxt;
    logic [c_hold_w-1:0] r_hold_cnt, w_hold_nxt;
    logic [3:0]          r_gap_cnt,  w_gap_nxt;
    logic                r_timeout,  w_timeout_nxt;
    logic                r_gnt_valid;

    pick_t               w_pick_idle;
    pick_t               w_pick_rearb;
    logic                w_owner_req;
    logic                w_expire;

    bin_encoder8to3 u_enc (
        .onehot (r_gnt),
        .idx    (gnt_idx)
    );

    // Normal search from the stored pointer; back-to-back search uses the
    // releasing owner as pointer so it lands last in the rotation.
    assign w_pick_idle  = rr_pick(req, r_ptr);
    assign w_pick_rearb = rr_pick(req, gnt_idx);
    assign w_owner_req  = req[gnt_idx];
    assign w_expire     = (MAX_HOLD != 0) && (r_hold_cnt == c_hold_last);

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_gap_nxt     = r_gap_cnt;
        w_timeout_nxt = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if (w_pick_idle.found) begin
                    w_gnt_nxt   = 8'b1 << w_pick_idle.idx;
                    w_hold_nxt  = '0;
                    w_state_nxt = ARB_BUSY;
                end
            end

            ARB_BUSY: begin
                if (!w_owner_req || w_expire) begin
                    w_ptr_nxt     = gnt_idx;
                    w_timeout_nxt = w_owner_req && w_expire;
                    if (GAP_CYCLES > 0) begin
                        w_gnt_nxt   = '0;
                        w_gap_nxt   = '0;
                        w_state_nxt = ARB_GAP;
                    end else if (w_pick_rearb.found) begin
                        w_gnt_nxt   = 8'b1 << w_pick_rearb.idx;
                        w_hold_nxt  = '0;
                    end else begin
                        w_gnt_nxt   = '0;
                        w_state_nxt = ARB_IDLE;
                    end
                end else if (r_hold_cnt != c_hold_max) begin
                    // Saturates only when MAX_HOLD = 0 (unlimited hold).
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end

            ARB_GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_state_nxt = ARB_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + 4'd1;
                end
            end

            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_ptr       <= 3'd7;
            r_hold_cnt  <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= |w_gnt_nxt;
            r_timeout   <= w_timeout_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gap_cnt   <= w_gap_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire
